// File: rtl/rv32_load_unit_pkg.sv
// ============================================================================
// Module  : rv32i_load_pkg
// Brief   : Shared types and constants for the RV32I load unit: load funct3
//           encodings, FSM states, fault codes and decode helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_load_pkg;

  // Load-type encodings carried in funct3
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

  // Load unit control states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    WB   = 3'd3,
    ERR  = 3'd4
  } state_e;

  // Fault codes reported alongside the fault pulse
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  // True for any funct3 that is not one of the five load types
  function automatic logic is_illegal_f3(input logic [2:0] f3);
    logic r;
    case (f3)
      LB, LH, LW, LBU, LHU: r = 1'b0;
      default:              r = 1'b1;
    endcase
    return r;
  endfunction

  // True when the access size does not match the low address bits
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic r;
    case (f3)
      LH, LHU: r = lo[0];
      LW:      r = (lo != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_load_unit_if.sv
// ============================================================================
// Module  : rv32_load_unit_if
// Brief   : Request, data-memory and register-file write signals of the load
//           unit. 'master' is the load unit side, 'slave' the environment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv32_load_unit_if;
  // Request from decode/execute
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] offset;
  logic [4:0]  rd;
  // Status
  logic        busy;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;
  // Data memory read channel
  logic [31:0] mem_addr;
  logic        mem_rd_req;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  // Register file write channel
  logic        rf_wr_ena;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  modport master (
    input  start, funct3, base, offset, rd, mem_rd_valid, mem_rd_data,
    output busy, done, fault, fault_code, mem_addr, mem_rd_req,
           rf_wr_ena, rf_wr_addr, rf_wr_data
  );

  modport slave (
    output start, funct3, base, offset, rd, mem_rd_valid, mem_rd_data,
    input  busy, done, fault, fault_code, mem_addr, mem_rd_req,
           rf_wr_ena, rf_wr_addr, rf_wr_data
  );
endinterface

`default_nettype wire

// File: rtl/rv32_load_unit_extender.sv
// ============================================================================
// Module  : load_extender
// Brief   : Combinational byte/half lane select and sign/zero extension of a
//           little-endian memory word for RV32I loads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extender
  import rv32i_load_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and half-word lanes
  always_comb begin
    w_byte = i_data[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_data[7:0];
      2'd1: w_byte = i_data[15:8];
      2'd2: w_byte = i_data[23:16];
      2'd3: w_byte = i_data[31:24];
      default: w_byte = i_data[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];
  end

  // Extend the selected lane according to the load type
  always_comb begin
    o_result = 32'd0;
    case (i_funct3)
      LB:      o_result = {{24{w_byte[7]}}, w_byte};
      LH:      o_result = {{16{w_half[15]}}, w_half};
      LW:      o_result = i_data;
      LBU:     o_result = {24'd0, w_byte};
      LHU:     o_result = {16'd0, w_half};
      default: o_result = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv32_load_unit.sv
// ============================================================================
// Module  : rv32_load_unit
// Brief   : Multi-cycle RV32I load stage. Issues a word-aligned read, waits for
//           the response, extends the addressed lane and writes the register
//           file for one cycle. Illegal and misaligned loads fault instead.
//           Optional build macro LOAD_TIMEOUT_EN adds a WAIT watchdog that
//           aborts with a timeout fault after TIMEOUT_CYCLES WAIT cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_load_unit
  import rv32i_load_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  rv32_load_unit_if.master       bus
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [31:0] r_data;
  logic [1:0]  r_fault_code;

  logic [31:0] w_addr;
  logic        w_illegal;
  logic        w_misalign;
  logic [31:0] w_result;
  logic        w_tmo_hit;

  logic        w_busy;
  logic        w_done;
  logic        w_fault;
  logic [1:0]  w_fault_code;
  logic [31:0] w_mem_addr;
  logic        w_mem_rd_req;
  logic        w_rf_wr_ena;
  logic [4:0]  w_rf_wr_addr;
  logic [31:0] w_rf_wr_data;

  // Effective address wraps modulo 2^32; classification uses the live request
  assign w_addr     = bus.base + bus.offset;
  assign w_illegal  = is_illegal_f3(bus.funct3);
  assign w_misalign = is_misaligned(bus.funct3, w_addr[1:0]);

  load_extender u_ext (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_data    (r_data),
    .o_result  (w_result)
  );

`ifdef LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;

  // Count WAIT cycles; cleared in REQ so every WAIT visit starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == REQ) begin
      r_tmo_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Counter holds (cycles already spent), so the limit is reached at the end
  // of the WAIT cycle whose count is one below TIMEOUT_CYCLES
  assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;

  // Without the watchdog WAIT never expires; parameter kept referenced
  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the request on acceptance and the memory word on response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= 32'd0;
      r_funct3     <= 3'd0;
      r_rd         <= 5'd0;
      r_data       <= 32'd0;
      r_fault_code <= FAULT_NONE;
    end else begin
      if (r_state == IDLE && bus.start) begin
        r_addr   <= w_addr;
        r_funct3 <= bus.funct3;
        r_rd     <= bus.rd;
        if (w_illegal) begin
          r_fault_code <= FAULT_ILLEGAL;
        end else if (w_misalign) begin
          r_fault_code <= FAULT_MISALIGN;
        end else begin
          r_fault_code <= FAULT_NONE;
        end
      end
      if (r_state == WAIT) begin
        if (bus.mem_rd_valid) begin
          r_data <= bus.mem_rd_data;
        end else if (w_tmo_hit) begin
          r_fault_code <= FAULT_TIMEOUT;
        end
      end
    end
  end

  // Next state and Moore outputs
  always_comb begin
    w_next       = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_fault      = 1'b0;
    w_fault_code = 2'b00;
    w_mem_addr   = 32'd0;
    w_mem_rd_req = 1'b0;
    w_rf_wr_ena  = 1'b0;
    w_rf_wr_addr = 5'd0;
    w_rf_wr_data = 32'd0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = (w_illegal || w_misalign) ? ERR : REQ;
        end
      end
      REQ: begin
        w_busy       = 1'b1;
        w_mem_rd_req = 1'b1;
        w_mem_addr   = {r_addr[31:2], 2'b00};
        w_next       = WAIT;
      end
      WAIT: begin
        w_busy     = 1'b1;
        w_mem_addr = {r_addr[31:2], 2'b00};
        if (bus.mem_rd_valid) begin
          w_next = WB;
        end else if (w_tmo_hit) begin
          w_next = ERR;
        end
      end
      WB: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_rf_wr_ena  = (r_rd != 5'd0);
        w_rf_wr_addr = r_rd;
        w_rf_wr_data = w_result;
        w_next       = IDLE;
      end
      ERR: begin
        w_busy       = 1'b1;
        w_fault      = 1'b1;
        w_fault_code = r_fault_code;
        w_next       = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.fault      = w_fault;
  assign bus.fault_code = w_fault_code;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_rd_req = w_mem_rd_req;
  assign bus.rf_wr_ena  = w_rf_wr_ena;
  assign bus.rf_wr_addr = w_rf_wr_addr;
  assign bus.rf_wr_data = w_rf_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_rv32_load_unit.sv
// ============================================================================
// Module  : tb_rv32_load_unit
// Brief   : Self-checking bench for rv32_load_unit: directed cases plus random
//           loads compared against an arithmetic reference model.
//           Honours LOAD_TIMEOUT_EN (watchdog limit of 4 WAIT cycles).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32_load_unit;

`ifdef LOAD_TIMEOUT_EN
  localparam int TMO     = 4;
  localparam bit TMO_EN  = 1'b1;
  localparam int DLY_MAX = 5;
`else
  localparam int TMO     = 255;
  localparam bit TMO_EN  = 1'b0;
  localparam int DLY_MAX = 12;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  rv32_load_unit_if bus ();

  rv32_load_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every output is zero whenever the unit is idle
  task automatic check_quiet(input string tag);
    check({tag, ".busy"},       32'(bus.busy),       32'd0);
    check({tag, ".done"},       32'(bus.done),       32'd0);
    check({tag, ".fault"},      32'(bus.fault),      32'd0);
    check({tag, ".fault_code"}, 32'(bus.fault_code), 32'd0);
    check({tag, ".mem_addr"},   bus.mem_addr,        32'd0);
    check({tag, ".mem_rd_req"}, 32'(bus.mem_rd_req), 32'd0);
    check({tag, ".rf_wr_ena"},  32'(bus.rf_wr_ena),  32'd0);
    check({tag, ".rf_wr_addr"}, 32'(bus.rf_wr_addr), 32'd0);
    check({tag, ".rf_wr_data"}, bus.rf_wr_data,      32'd0);
  endtask

  // Reference: what a load should produce, from address arithmetic and sizes
  function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] w, input int dly,
                                output logic [1:0] code, output logic [31:0] res);
    int     size;
    bit     sgn;
    bit     legal;
    longint v;
    int     bits;
    legal = 1'b1;
    size  = 4;
    sgn   = 1'b0;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 4; sgn = 1'b0; end
      3'd4: begin size = 1; sgn = 1'b0; end
      3'd5: begin size = 2; sgn = 1'b0; end
      default: legal = 1'b0;
    endcase
    if (!legal)                      code = 2'd2;
    else if ((a % size) != 0)        code = 2'd1;
    else if (TMO_EN && dly >= TMO)   code = 2'd3;
    else                             code = 2'd0;
    bits = 8 * size;
    v    = longint'(w) >> (8 * (a % 4));
    if (size == 4) begin
      res = w;
    end else begin
      v = v % (longint'(1) << bits);
      if (sgn && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
      res = v[31:0];
    end
  endfunction

  // Drive one load from IDLE and check every cycle until IDLE again.
  // dly = WAIT cycles before the response; poke = hammer start and
  // mem_rd_valid while busy, both of which must be ignored.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] b,
                          input logic [31:0] o, input logic [4:0] rd,
                          input logic [31:0] data, input int dly, input bit poke);
    logic [31:0] a;
    logic [1:0]  ecode;
    logic [31:0] eres;
    int          nwait;
    a = b + o;
    model(f3, a, data, dly, ecode, eres);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.base   = b;
    bus.offset = o;
    bus.rd     = rd;
    tick();
    bus.start = poke;
    if (poke) begin
      bus.funct3       = 3'($urandom);
      bus.base         = $urandom;
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = ~data;
    end
    if (ecode == 2'd1 || ecode == 2'd2) begin
      check({tag, ".fault"},  32'(bus.fault),      32'd1);
      check({tag, ".code"},   32'(bus.fault_code), 32'(ecode));
      check({tag, ".reqerr"}, 32'(bus.mem_rd_req), 32'd0);
      check({tag, ".wrerr"},  32'(bus.rf_wr_ena),  32'd0);
      check({tag, ".doneerr"},32'(bus.done),       32'd0);
    end else begin
      check({tag, ".req"},  32'(bus.mem_rd_req), 32'd1);
      check({tag, ".addr"}, bus.mem_addr,        {a[31:2], 2'b00});
      check({tag, ".busy"}, 32'(bus.busy),       32'd1);
      tick();
      bus.mem_rd_valid = 1'b0;
      nwait = (ecode == 2'd3) ? TMO : dly + 1;
      for (int k = 0; k < nwait; k++) begin
        check({tag, ".wreq"},  32'(bus.mem_rd_req), 32'd0);
        check({tag, ".waddr"}, bus.mem_addr,        {a[31:2], 2'b00});
        check({tag, ".wdone"}, 32'(bus.done),       32'd0);
        check({tag, ".wflt"},  32'(bus.fault),      32'd0);
        if (ecode == 2'd0 && k == nwait - 1) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = data;
        end
        tick();
        bus.mem_rd_valid = 1'b0;
      end
      if (ecode == 2'd3) begin
        check({tag, ".tfault"}, 32'(bus.fault),      32'd1);
        check({tag, ".tcode"},  32'(bus.fault_code), 32'd3);
        check({tag, ".twr"},    32'(bus.rf_wr_ena),  32'd0);
      end else begin
        check({tag, ".done"},   32'(bus.done),       32'd1);
        check({tag, ".wena"},   32'(bus.rf_wr_ena),  32'(rd != 5'd0));
        check({tag, ".waddr"},  32'(bus.rf_wr_addr), 32'(rd));
        check({tag, ".wdata"},  bus.rf_wr_data,      eres);
        check({tag, ".wbflt"},  32'(bus.fault),      32'd0);
      end
    end
    tick();
    bus.start        = 1'b0;
    bus.mem_rd_valid = 1'b0;
    check_quiet({tag, ".post"});
    if (poke) begin
      tick();
      check_quiet({tag, ".ignored"});
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] b;
    logic [31:0] o;
    logic [4:0]  rd;
    bus.start        = 1'b0;
    bus.funct3       = 3'd0;
    bus.base         = 32'd0;
    bus.offset       = 32'd0;
    bus.rd           = 5'd0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = 32'd0;

    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    run_load("lb",     3'b000, 32'h1000, 32'h3,        5'd5,  32'h80FF1234, 0,  1'b0);
    run_load("lhu",    3'b101, 32'h1004, 32'hFFFFFFFE, 5'd9,  32'h80FF1234, 0,  1'b0);
    run_load("lh",     3'b001, 32'h1004, 32'hFFFFFFFE, 5'd9,  32'h80FF1234, 0,  1'b0);
    run_load("lwmis",  3'b010, 32'h1000, 32'h1,        5'd3,  32'h0,        0,  1'b0);
    run_load("illf3",  3'b011, 32'h1000, 32'h0,        5'd3,  32'h0,        0,  1'b0);
    run_load("illmis", 3'b110, 32'h1000, 32'h1,        5'd3,  32'h0,        0,  1'b0);
    run_load("x0",     3'b010, 32'h2000, 32'h0,        5'd0,  32'hDEADBEEF, 1,  1'b1);
    run_load("wrap",   3'b100, 32'hFFFFFFFF, 32'h3,    5'd31, 32'h12345678, 2,  1'b0);
    run_load("dly10",  3'b010, 32'h3000, 32'h4,        5'd7,  32'hCAFEF00D, 10, 1'b0);
`ifdef LOAD_TIMEOUT_EN
    run_load("tmoedge", 3'b010, 32'h3000, 32'h0, 5'd8, 32'h13579BDF, TMO - 1, 1'b0);
    run_load("tmo",     3'b010, 32'h3000, 32'h0, 5'd8, 32'h13579BDF, TMO,     1'b1);
`endif

    // Reset during WAIT, then a late response that must be dropped
    bus.start  = 1'b1;
    bus.funct3 = 3'b010;
    bus.base   = 32'h4000;
    bus.offset = 32'h8;
    bus.rd     = 5'd12;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("rstmid.busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("rstmid");
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_data  = 32'hA5A5A5A5;
    tick();
    rst = 1'b0;
    tick();
    bus.mem_rd_valid = 1'b0;
    check_quiet("rstlate");
    tick();
    check_quiet("rstidle");

    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(0, 7));
      b  = $urandom;
      o  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_load("rnd", f3, b, o, rd, $urandom, int'($urandom_range(0, DLY_MAX)),
               $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
